// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared mode constants, channel configuration payload and the
// square-wave half-point helper used by every divider channel.
package clkdiv_pkg;

  // Widest divisor a channel can hold; narrower WIDTH values zero-extend.
  localparam int unsigned DIV_W_MAX = 32;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // One channel's configuration: divisor D (period D+1) and output mode.
  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic                 mode;
  } clkdiv_cfg_t;

  // H = (D+2)>>1, carried one bit wider so the largest D cannot wrap.
  function automatic logic [DIV_W_MAX:0] half_point(input logic [DIV_W_MAX-1:0] div);
    return ((DIV_W_MAX + 1)'(div) + (DIV_W_MAX + 1)'(2)) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_bank_if.sv
// clkdiv_bank_if: control/config inputs and divided outputs of clkdiv_bank.
//   enable      per-channel run enable
//   sync        restart and phase-align all channels
//   cfg_we/ch/div/mode  configuration write into one channel's shadow
//   tick        one-cycle pulse per period (per channel)
//   clkout      divided output, pulse or square depending on mode
//   cfg_pending shadow written but not yet active
interface clkdiv_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] enable;
  logic                sync;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [WIDTH-1:0]    cfg_div;
  logic                cfg_mode;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] clkout;
  logic [CHANNELS-1:0] cfg_pending;

  modport master (
    output enable, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
    input  tick, clkout, cfg_pending
  );

  modport slave (
    input  enable, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
    output tick, clkout, cfg_pending
  );
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one programmable divider. Counts 0..D, emits a registered
// tick on c==D and a pulse or ~50% square clkout. New configuration waits in
// a shadow until the period ends, the channel is idle, or sync restarts it.
//   clk, rst_n  clock, async active-low reset
//   i_enable    run enable; low clears counter and outputs
//   i_sync      restart counter, clear outputs, apply shadow
//   i_we, i_cfg configuration write for this channel
//   o_tick, o_clkout, o_pending  registered outputs
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_sync,
  input  logic        i_we,
  input  clkdiv_cfg_t i_cfg,
  output logic        o_tick,
  output logic        o_clkout,
  output logic        o_pending
);

  localparam clkdiv_cfg_t CFG_RESET = '{div: DIV_W_MAX'(DEFAULT_DIV), mode: MODE_PULSE};

  logic [WIDTH-1:0] r_cnt;
  clkdiv_cfg_t      r_active;
  clkdiv_cfg_t      r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_clkout;

  logic [WIDTH-1:0] w_cnt_nxt;
  clkdiv_cfg_t      w_active_nxt;
  clkdiv_cfg_t      w_shadow_nxt;
  logic             w_pending_nxt;
  logic             w_tick_nxt;
  logic             w_clkout_nxt;

  logic             w_hold;
  logic             w_at_top;
  logic             w_below_half;
  logic             w_apply;

  // Counter compared at full config width so the comparison stays exact.
  assign w_at_top     = (DIV_W_MAX'(r_cnt) == r_active.div);
  assign w_below_half = ((DIV_W_MAX + 1)'(r_cnt) < half_point(r_active.div));
  assign w_hold       = i_sync || !i_enable;
  // Period boundary, idle channel or sync: safe point to switch config.
  assign w_apply      = w_hold || w_at_top;

  // Next-state: counter, outputs, and active/shadow configuration.
  always_comb begin
    w_cnt_nxt     = '0;
    w_tick_nxt    = 1'b0;
    w_clkout_nxt  = 1'b0;
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;

    if (!w_hold) begin
      w_cnt_nxt    = w_at_top ? '0 : r_cnt + WIDTH'(1);
      w_tick_nxt   = w_at_top;
      w_clkout_nxt = (r_active.mode == MODE_SQUARE) ? w_below_half : w_at_top;
    end

    if (w_apply) begin
      // A write landing on the apply edge bypasses the shadow.
      if (i_we) begin
        w_active_nxt  = i_cfg;
        w_pending_nxt = 1'b0;
      end else if (r_pending) begin
        w_active_nxt  = r_shadow;
        w_pending_nxt = 1'b0;
      end
    end else if (i_we) begin
      w_shadow_nxt  = i_cfg;
      w_pending_nxt = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_active  <= CFG_RESET;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_clkout  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_tick    <= w_tick_nxt;
      r_clkout  <= w_clkout_nxt;
    end
  end

  assign o_tick    = r_tick;
  assign o_clkout  = r_clkout;
  assign o_pending = r_pending;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: CHANNELS independent programmable clock dividers.
//   clkin  sole clock, rising edge
//   reset  async active-low reset
//   bus    clkdiv_bank_if slave: enables, sync, config write, outputs
// Decodes cfg_ch into per-channel write strobes (out-of-range writes hit no
// channel) and fans sync out to every channel.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic          clkin,
  input  logic          reset,
  clkdiv_bank_if.slave  bus
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  clkdiv_cfg_t         w_cfg;
  logic [CHANNELS-1:0] w_we;
  logic [CHANNELS-1:0] w_tick;
  logic [CHANNELS-1:0] w_clkout;
  logic [CHANNELS-1:0] w_pending;

  assign w_cfg = '{div: DIV_W_MAX'(bus.cfg_div), mode: bus.cfg_mode};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_we[g] = bus.cfg_we && (bus.cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clk       (clkin),
      .rst_n     (reset),
      .i_enable  (bus.enable[g]),
      .i_sync    (bus.sync),
      .i_we      (w_we[g]),
      .i_cfg     (w_cfg),
      .o_tick    (w_tick[g]),
      .o_clkout  (w_clkout[g]),
      .o_pending (w_pending[g])
    );
  end

  assign bus.tick        = w_tick;
  assign bus.clkout      = w_clkout;
  assign bus.cfg_pending = w_pending;

endmodule

// File: doc/clkdiv_bank.md
# clkdiv_bank

Multi-channel programmable clock-enable and divided-clock generator: the parametrised successor of the fixed four-ratio divider. Each of `CHANNELS` independent channels divides `clkin` by any runtime ratio 1..2^`WIDTH`. Each channel produces a one-cycle tick or a near-50% square wave. Ratio changes are glitch-free, and a global sync input phase-aligns all channels. The block sits beside the counter/display logic and supplies their enables and slow clocks.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16)
- `WIDTH`, 16: divisor/counter width
- `DEFAULT_DIV`, 1: divisor loaded into every channel at reset (period = `DEFAULT_DIV`+1)
- `clkin`  in  1: sole clock, all logic on rising edge
- `reset`  in  1: asynchronous, active-low reset
- `enable`  in  `CHANNELS`: per-channel run enable
- `sync`  in  1: synchronous restart of all channels
- `cfg_we`  in  1: configuration write strobe
- `cfg_ch`  in  $clog2(`CHANNELS`) (min 1): target channel of the write
- `cfg_div`  in  `WIDTH`: new divisor D; period = D+1 cycles
- `cfg_mode`  in  1: 0 = pulse, 1 = square
- `tick`  out  `CHANNELS`: registered one-cycle pulse per period
- `clkout`  out  `CHANNELS`: registered divided output, mode-dependent
- `cfg_pending`  out  `CHANNELS`: shadow config written but not yet applied

## Operation
- **Reset** (`reset`=0, asynchronous): for every channel
  - counter c=0, active D=`DEFAULT_DIV`, mode=pulse
  - shadow cleared
  - `tick`=0, `clkout`=0, `cfg_pending`=0
- **Counting.** On each edge with `enable[i]`=1: c <= (c==D) ? 0 : c+1.
  - Range: 0 ≤ c ≤ D at all times, so no counter overflow.
- **Tick.** `tick[i]` <= `enable[i]` && (c==D), evaluated on the current c.
- **Square mode.** `clkout[i]` <= `enable[i]` && (c < H), with H = (D+2)>>1.
  - Result: high for ceil((D+1)/2) cycles, low for the rest of the period.
  - H is computed in `WIDTH`+1 bits so D = 2^`WIDTH`−1 does not overflow.
- **Pulse mode.** `clkout[i]` <= the same value as `tick[i]`.
- **D=0.** `tick` and `clkout` are constant 1 while enabled, in both modes.
- **Configuration write.**
  - `cfg_we`=1 with `cfg_ch` < `CHANNELS`: stores {`cfg_div`, `cfg_mode`} in that channel's shadow and sets `cfg_pending`.
  - `cfg_ch` ≥ `CHANNELS`: the write is ignored.
  - Several writes before application: the last write wins.
- **Applying the shadow.** The pending shadow becomes active at the first of:
  - the channel's wrap edge (`enable`=1 and c==D), where c restarts at 0 under the new D;
  - any edge with `enable[i]`=0;
  - a `sync` edge.
- **Write coincident with apply.** The write data bypasses the shadow: the new value becomes active on that edge and `cfg_pending` stays 0.
- **Disabled** (`enable[i]`=0): c <= 0, `tick[i]` <= 0, `clkout[i]` <= 0.
- **Sync** (`sync`=1), for all channels:
  - c <= 0, `tick` <= 0, `clkout` <= 0
  - pending shadows applied
  - `sync` overrides wrap and enable for that edge.

## Timing
- Enable sampled high at edge 0 with c=0:
  - `tick` is first high in the cycle after edge D, then every D+1 cycles.
  - Square `clkout` is first high in the cycle after edge 0.
- Output latency: one register stage from the counter state; no combinational path from input to output.
- A divisor change never produces a truncated period: the current period completes under the old D.
- Reset deassertion: the first counting edge is the first edge with `reset`=1 and `enable` high.

## Structure
- Package `clkdiv_pkg`:
  - mode constants `MODE_PULSE`=1'b0, `MODE_SQUARE`=1'b1
  - channel config struct {div, mode}
- Sub-module `clkdiv_channel`, with `WIDTH`/`DEFAULT_DIV` parameters:
  - contains counter, active/shadow config, apply logic and output registers
  - instantiated `CHANNELS` times in a generate loop
- The top level decodes `cfg_ch` into per-channel write strobes and fans out `sync`.

## Test plan
- **Default ratio.** Reset, then `enable`=all ones with D=1 in pulse mode -> each `tick` high every 2nd cycle, first in the cycle after edge 1; `clkout`==`tick`.
- **Square, odd period.** Write ch2 D=4, square mode, enable -> `clkout[2]` high 3 cycles, low 2, repeating, first high in the cycle after edge 0; `tick[2]` every 5 cycles.
- **Mid-period ratio change.** Ch0 running at D=7, write D=2 at c=3 -> `cfg_pending[0]`=1 until the wrap. Observed tick spacing: 8 (old period completes), then 3, 3, ...
- **Write on wrap edge.** Write lands on the wrap edge -> applied immediately, `cfg_pending` never asserts. Out-of-range `cfg_ch` -> no state change.
- **Sync alignment.** Channels at D=3 and D=5 with arbitrary phases, pulse `sync` -> all counters 0, outputs 0 that cycle. First ticks follow 4 and 6 cycles later respectively.
- **Reset mid-operation.** `reset` low asynchronously mid-period -> outputs 0 immediately, D back to `DEFAULT_DIV`, pending cleared. Extremes: D=0 gives constant-1 outputs; D=2^`WIDTH`−1 gives a period of 2^`WIDTH` with no overflow.
